sap_1_controller_sequencer: RTL

Parametrised SAP-1 controller-sequencer: a 6-state one-hot ring counter (T1–T6) combined with opcode decode that drives every control line of the SAP-1 datapath. It sits between the instruction register's opcode field and the PC, MAR, RAM, IR, accumulator, B, ALU and output registers. It generalises plain opcode decode with:
- configurable opcode width and encodings,
- fetch/execute sequencing,
- a sticky halt,
- optional early end of the machine cycle,
- an optional illegal-opcode trap.

---
 rtl/sap_1_controller_sequencer_if.sv | 31 +++
 rtl/sap_1_controller_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sap_1_controller_sequencer_if.sv
// SAP-1 controller/datapath control bundle: opcode in, ring state and
// control lines out. ILL exists only when SAP_1_ILLEGAL_TRAP_EN is defined.
interface sap_1_controller_sequencer_if #(
   parameter int OPCODE_WIDTH = 4
);
   logic [OPCODE_WIDTH-1:0] IR_OP;
   logic [5:0]              T;
   logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo;
   logic HLT;
`ifdef SAP_1_ILLEGAL_TRAP_EN
   logic ILL;
`endif

   // controller side
   modport master (
      input  IR_OP,
      output T, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT
`ifdef SAP_1_ILLEGAL_TRAP_EN
      , output ILL
`endif
   );

   // datapath side
   modport slave (
      output IR_OP,
      input  T, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT
`ifdef SAP_1_ILLEGAL_TRAP_EN
      , input  ILL
`endif
   );
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring (T1..T6) plus opcode
// decode driving every datapath control line. Sticky halt, optional early
// return to T1 (SKIP_IDLE), optional illegal-opcode trap selected by the
// SAP_1_ILLEGAL_TRAP_EN macro (undefined: undefined opcodes run as NOP).
//
// state | meaning
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR
// T4    | execute 1 (also the parking state once halted)
// T5    | execute 2
// T6    | execute 3
module sap_1_controller_sequencer #(
   parameter int OPCODE_WIDTH = 4,
   parameter int OP_LDA       = 0,
   parameter int OP_ADD       = 1,
   parameter int OP_SUB       = 2,
   parameter int OP_OUT       = 14,
   parameter int OP_HLT       = 15,
   parameter bit SKIP_IDLE    = 1'b0
) (
   input logic                          CLK,
   input logic                          CLR,
   sap_1_controller_sequencer_if.master ctl_if
);

   if (OPCODE_WIDTH < 3) begin : g_width_check
      $error("sap_1_controller_sequencer: OPCODE_WIDTH must be at least 3");
   end

   typedef enum logic [5:0] {
      ST_T1 = 6'b000001,
      ST_T2 = 6'b000010,
      ST_T3 = 6'b000100,
      ST_T4 = 6'b001000,
      ST_T5 = 6'b010000,
      ST_T6 = 6'b100000
   } state_e;

   localparam logic [OPCODE_WIDTH-1:0] LP_LDA = OP_LDA[OPCODE_WIDTH-1:0];
   localparam logic [OPCODE_WIDTH-1:0] LP_ADD = OP_ADD[OPCODE_WIDTH-1:0];
   localparam logic [OPCODE_WIDTH-1:0] LP_SUB = OP_SUB[OPCODE_WIDTH-1:0];
   localparam logic [OPCODE_WIDTH-1:0] LP_OUT = OP_OUT[OPCODE_WIDTH-1:0];
   localparam logic [OPCODE_WIDTH-1:0] LP_HLT = OP_HLT[OPCODE_WIDTH-1:0];

   state_e r_state;
   state_e w_state_nxt;
   logic   r_halted;
   logic   w_halted_nxt;
`ifdef SAP_1_ILLEGAL_TRAP_EN
   logic   r_ill;
   logic   w_ill_nxt;
`endif

   logic w_op_lda, w_op_add, w_op_sub, w_op_out, w_op_hlt, w_op_alu;
   logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo;
   logic w_run;

   assign w_op_lda = (ctl_if.IR_OP == LP_LDA);
   assign w_op_add = (ctl_if.IR_OP == LP_ADD);
   assign w_op_sub = (ctl_if.IR_OP == LP_SUB);
   assign w_op_out = (ctl_if.IR_OP == LP_OUT);
   assign w_op_hlt = (ctl_if.IR_OP == LP_HLT);
   assign w_op_alu = w_op_add | w_op_sub;

   // State register: ring position, sticky halt and trap flag; CLR wins.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_state  <= ST_T1;
         r_halted <= 1'b0;
`ifdef SAP_1_ILLEGAL_TRAP_EN
         r_ill    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= w_halted_nxt;
`ifdef SAP_1_ILLEGAL_TRAP_EN
         r_ill    <= w_ill_nxt;
`endif
      end
   end

   // Next ring position and raw control lines from ring state and opcode.
   always_comb begin
      w_state_nxt  = r_state;
      w_halted_nxt = r_halted;
`ifdef SAP_1_ILLEGAL_TRAP_EN
      w_ill_nxt    = r_ill;
`endif
      w_cp = 1'b0; w_ep = 1'b0; w_lm = 1'b0; w_ce = 1'b0;
      w_li = 1'b0; w_ei = 1'b0; w_la = 1'b0; w_ea = 1'b0;
      w_su = 1'b0; w_eu = 1'b0; w_lb = 1'b0; w_lo = 1'b0;
      if (!r_halted) begin
         case (r_state)
            ST_T1: begin
               w_ep = 1'b1;
               w_lm = 1'b1;
               w_state_nxt = ST_T2;
            end
            ST_T2: begin
               w_cp = 1'b1;
               w_state_nxt = ST_T3;
            end
            ST_T3: begin
               w_ce = 1'b1;
               w_li = 1'b1;
               w_state_nxt = ST_T4;
            end
            ST_T4: begin
               if (w_op_lda || w_op_alu) begin
                  w_ei = 1'b1;
                  w_lm = 1'b1;
                  w_state_nxt = ST_T5;
               end else if (w_op_out) begin
                  w_ea = 1'b1;
                  w_lo = 1'b1;
                  w_state_nxt = SKIP_IDLE ? ST_T1 : ST_T5;
               end else if (w_op_hlt) begin
                  // park in T4; the halted flag blanks all lines from here on
                  w_halted_nxt = 1'b1;
               end else begin
`ifdef SAP_1_ILLEGAL_TRAP_EN
                  w_halted_nxt = 1'b1;
                  w_ill_nxt    = 1'b1;
`else
                  w_state_nxt = SKIP_IDLE ? ST_T1 : ST_T5;
`endif
               end
            end
            ST_T5: begin
               if (w_op_lda) begin
                  w_ce = 1'b1;
                  w_la = 1'b1;
                  w_state_nxt = SKIP_IDLE ? ST_T1 : ST_T6;
               end else if (w_op_alu) begin
                  w_ce = 1'b1;
                  w_lb = 1'b1;
                  w_state_nxt = ST_T6;
               end else begin
                  w_state_nxt = ST_T6;
               end
            end
            ST_T6: begin
               if (w_op_alu) begin
                  w_eu = 1'b1;
                  w_la = 1'b1;
                  w_su = w_op_sub;
               end
               w_state_nxt = ST_T1;
            end
            default: w_state_nxt = ST_T1;
         endcase
      end
   end

   assign w_run = ~CLR & ~r_halted;

   assign ctl_if.T   = r_state;
   assign ctl_if.HLT = r_halted;
`ifdef SAP_1_ILLEGAL_TRAP_EN
   assign ctl_if.ILL = r_ill;
`endif
   assign ctl_if.Cp = w_cp & w_run;
   assign ctl_if.Ep = w_ep & w_run;
   assign ctl_if.Lm = w_lm & w_run;
   assign ctl_if.CE = w_ce & w_run;
   assign ctl_if.Li = w_li & w_run;
   assign ctl_if.Ei = w_ei & w_run;
   assign ctl_if.La = w_la & w_run;
   assign ctl_if.Ea = w_ea & w_run;
   assign ctl_if.Su = w_su & w_run;
   assign ctl_if.Eu = w_eu & w_run;
   assign ctl_if.Lb = w_lb & w_run;
   assign ctl_if.Lo = w_lo & w_run;

endmodule
